// File: rtl/lsu_beat_ctrl.sv
// Load/store access controller: handshaked FSM between the M-stage and the data bus,
// with lane alignment, sign/zero extension and two-beat splitting of boundary-crossing accesses.
module lsu_beat_ctrl #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_exc
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_next;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_lo;
  logic [DATA_W-1:0] buf_hi;
  logic              cross_q;
  logic              exc_q;

  logic [OFF_W-1:0]    req_off;
  logic [3:0]          req_n;
  logic                req_cross;
  logic                req_exc;
  logic                accept;

  logic [OFF_W-1:0]    off;
  logic [3:0]          n;
  logic [ADDR_W-1:0]   base_addr;
  logic [2*B-1:0]      mask_full;
  logic [2*DATA_W-1:0] wdata_full;
  logic [DATA_W-1:0]   load_raw;
  logic [DATA_W-1:0]   load_ext;
  logic [IDX_W-1:0]    sign_idx;
  logic                sign_bit;

  // Request classification, evaluated against the incoming address/op before latching.
  assign req_off   = req_addr[OFF_W-1:0];
  assign req_n     = 4'd1 << req_op[1:0];
  assign req_cross = (int'(req_off) + int'(req_n)) > B;
  assign req_exc   = (req_cross && !ALLOW_MISALIGNED) || ((req_op[1:0] == 2'd3) && (DATA_W == 32));
  assign accept    = (state == IDLE) && req_valid;

  assign off       = addr_q[OFF_W-1:0];
  assign n         = 4'd1 << op_q[1:0];
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Double-width mask and data; the low half feeds BEAT0, the high half BEAT1.
  always_comb begin
    mask_full = '0;
    for (int i = 0; i < 2*B; i++) begin
      mask_full[i] = (i < int'(n));
    end
    mask_full  = mask_full << off;
    wdata_full = {{DATA_W{1'b0}}, wdata_q} << {off, 3'b000};
  end

  always_comb begin
    load_raw = DATA_W'({buf_hi, buf_lo} >> {off, 3'b000});
    sign_idx = IDX_W'(8 * int'(n) - 1);
    sign_bit = load_raw[sign_idx] & ~op_q[2];
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < 8 * int'(n)) ? load_raw[i] : sign_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_byteen = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_exc   = 1'b0;
    resp_rdata = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_exc ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        mem_req    = 1'b1;
        mem_we     = op_q[3];
        mem_addr   = base_addr;
        mem_byteen = mask_full[B-1:0];
        mem_wdata  = wdata_full[DATA_W-1:0];
        if (mem_ack) begin
          state_next = cross_q ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        mem_req    = 1'b1;
        mem_we     = op_q[3];
        mem_addr   = base_addr + ADDR_W'(B);
        mem_byteen = mask_full[2*B-1:B];
        mem_wdata  = wdata_full[2*DATA_W-1:DATA_W];
        if (mem_ack) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_exc   = exc_q;
        resp_rdata = (exc_q || op_q[3]) ? '0 : load_ext;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Access context is frozen at acceptance so mem_* stay stable across wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      exc_q   <= 1'b0;
      buf_lo  <= '0;
      buf_hi  <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cross_q <= req_cross;
        exc_q   <= req_exc;
      end
      if (state == BEAT0 && mem_ack) begin
        buf_lo <= mem_rdata;
      end
      if (state == BEAT1 && mem_ack) begin
        buf_hi <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_beat_ctrl.sv
// Directed bench for lsu_beat_ctrl: one instance with misaligned splitting, one that traps it.
module tb_lsu_beat_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid_a, req_ready_a, mem_req_a, mem_we_a, mem_ack_a;
  logic        resp_valid_a, resp_exc_a;
  logic [3:0]  req_op_a, mem_byteen_a;
  logic [31:0] req_addr_a, req_wdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a, resp_rdata_a;

  logic        req_valid_b, req_ready_b, mem_req_b, mem_we_b, mem_ack_b;
  logic        resp_valid_b, resp_exc_b;
  logic [3:0]  req_op_b, mem_byteen_b;
  logic [31:0] req_addr_b, req_wdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b, resp_rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_beat_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_op(req_op_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_byteen(mem_byteen_a), .mem_wdata(mem_wdata_a),
    .mem_ack(mem_ack_a), .mem_rdata(mem_rdata_a),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_exc(resp_exc_a)
  );

  lsu_beat_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_byteen(mem_byteen_b), .mem_wdata(mem_wdata_b),
    .mem_ack(mem_ack_b), .mem_rdata(mem_rdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_exc(resp_exc_b)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One non-crossing access on dut_a, with a given number of wait cycles before ack.
  task automatic single_beat(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                             input logic e_we, input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wd, input logic [31:0] e_rd);
    req_valid_a = 1'b1;
    req_op_a    = op;
    req_addr_a  = addr;
    req_wdata_a = wdata;
    check_output({tag, "_ready"}, req_ready_a, 1'b1);
    tick;
    req_valid_a = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      check_output({tag, "_mreq"}, mem_req_a, 1'b1);
      check_output({tag, "_we"}, mem_we_a, e_we);
      check_output({tag, "_addr"}, mem_addr_a, e_addr);
      check_output({tag, "_be"}, mem_byteen_a, e_be);
      check_output({tag, "_wd"}, mem_wdata_a, e_wd);
      check_output({tag, "_nresp"}, resp_valid_a, 1'b0);
      if (w == waits) begin
        mem_ack_a   = 1'b1;
        mem_rdata_a = rdata;
      end
      tick;
    end
    mem_ack_a   = 1'b0;
    mem_rdata_a = '0;
    check_output({tag, "_rvalid"}, resp_valid_a, 1'b1);
    check_output({tag, "_rdata"}, resp_rdata_a, e_rd);
    check_output({tag, "_exc"}, resp_exc_a, 1'b0);
    check_output({tag, "_busy"}, req_ready_a, 1'b0);
    tick;
    check_output({tag, "_pulse"}, resp_valid_a, 1'b0);
    check_output({tag, "_idle"}, req_ready_a, 1'b1);
  endtask

  // Trapped access on dut_b: response at T+1, no bus activity.
  task automatic exc_case(input string tag, input logic [3:0] op, input logic [31:0] addr);
    req_valid_b = 1'b1;
    req_op_b    = op;
    req_addr_b  = addr;
    tick;
    req_valid_b = 1'b0;
    check_output({tag, "_mreq"}, mem_req_b, 1'b0);
    check_output({tag, "_rvalid"}, resp_valid_b, 1'b1);
    check_output({tag, "_exc"}, resp_exc_b, 1'b1);
    check_output({tag, "_rdata"}, resp_rdata_b, 32'h0);
    check_output({tag, "_busy"}, req_ready_b, 1'b0);
    tick;
    check_output({tag, "_mreq2"}, mem_req_b, 1'b0);
    check_output({tag, "_pulse"}, resp_valid_b, 1'b0);
    check_output({tag, "_idle"}, req_ready_b, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid_a = 1'b0; req_op_a = '0; req_addr_a = '0; req_wdata_a = '0;
    mem_ack_a   = 1'b0; mem_rdata_a = '0;
    req_valid_b = 1'b0; req_op_b = '0; req_addr_b = '0; req_wdata_b = '0;
    mem_ack_b   = 1'b0; mem_rdata_b = '0;
    repeat (2) tick;
    reset = 1'b0;

    check_output("rst_ready", req_ready_a, 1'b1);
    check_output("rst_mreq", mem_req_a, 1'b0);
    check_output("rst_we", mem_we_a, 1'b0);
    check_output("rst_addr", mem_addr_a, 32'h0);
    check_output("rst_be", mem_byteen_a, 4'h0);
    check_output("rst_wd", mem_wdata_a, 32'h0);
    check_output("rst_rvalid", resp_valid_a, 1'b0);
    check_output("rst_exc", resp_exc_a, 1'b0);
    check_output("rst_rdata", resp_rdata_a, 32'h0);

    single_beat("lw",    4'b0010, 32'h100, 32'h0, 32'h800000F0, 0, 1'b0, 32'h100, 4'b1111, 32'h0, 32'h800000F0);
    single_beat("lb",    4'b0000, 32'h103, 32'h0, 32'h80123456, 0, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    single_beat("lbu",   4'b0100, 32'h103, 32'h0, 32'h80123456, 0, 1'b0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
    single_beat("lb_ws", 4'b0000, 32'h103, 32'h0, 32'h80123456, 2, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    single_beat("lh",    4'b0001, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
    single_beat("sh",    4'b1001, 32'h102, 32'h0000BEEF, 32'h0, 0, 1'b1, 32'h100, 4'b1100, 32'hBEEF0000, 32'h0);

    // Misaligned store split into two beats
    req_valid_a = 1'b1; req_op_a = 4'b1010; req_addr_a = 32'h101; req_wdata_a = 32'hAABBCCDD;
    tick;
    req_valid_a = 1'b0;
    check_output("sw_b0_mreq", mem_req_a, 1'b1);
    check_output("sw_b0_we", mem_we_a, 1'b1);
    check_output("sw_b0_addr", mem_addr_a, 32'h100);
    check_output("sw_b0_be", mem_byteen_a, 4'b1110);
    check_output("sw_b0_wd", mem_wdata_a, 32'hBBCCDD00);
    mem_ack_a = 1'b1;
    tick;
    mem_ack_a = 1'b0;
    check_output("sw_b1_mreq", mem_req_a, 1'b1);
    check_output("sw_b1_addr", mem_addr_a, 32'h104);
    check_output("sw_b1_be", mem_byteen_a, 4'b0001);
    check_output("sw_b1_wd", mem_wdata_a, 32'h000000AA);
    check_output("sw_b1_nresp", resp_valid_a, 1'b0);
    mem_ack_a = 1'b1;
    tick;
    mem_ack_a = 1'b0;
    check_output("sw_rvalid", resp_valid_a, 1'b1);
    check_output("sw_rdata", resp_rdata_a, 32'h0);
    check_output("sw_exc", resp_exc_a, 1'b0);
    tick;

    // Misaligned load reassembled from two beats
    req_valid_a = 1'b1; req_op_a = 4'b0010; req_addr_a = 32'h101; req_wdata_a = 32'h0;
    tick;
    req_valid_a = 1'b0;
    check_output("lw2_b0_addr", mem_addr_a, 32'h100);
    check_output("lw2_b0_be", mem_byteen_a, 4'b1110);
    check_output("lw2_b0_we", mem_we_a, 1'b0);
    mem_ack_a = 1'b1; mem_rdata_a = 32'hBBCCDD00;
    tick;
    mem_rdata_a = 32'h000000AA;
    check_output("lw2_b1_addr", mem_addr_a, 32'h104);
    check_output("lw2_b1_be", mem_byteen_a, 4'b0001);
    tick;
    mem_ack_a = 1'b0; mem_rdata_a = '0;
    check_output("lw2_rvalid", resp_valid_a, 1'b1);
    check_output("lw2_rdata", resp_rdata_a, 32'hAABBCCDD);
    tick;

    // Reset while BEAT1 is waiting
    req_valid_a = 1'b1; req_op_a = 4'b0010; req_addr_a = 32'h102;
    tick;
    req_valid_a = 1'b0;
    mem_ack_a = 1'b1; mem_rdata_a = 32'h11111111;
    tick;
    mem_ack_a = 1'b0; mem_rdata_a = '0;
    check_output("rb_b1_mreq", mem_req_a, 1'b1);
    check_output("rb_b1_addr", mem_addr_a, 32'h104);
    check_output("rb_b1_be", mem_byteen_a, 4'b0011);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_output("rb_mreq", mem_req_a, 1'b0);
    check_output("rb_ready", req_ready_a, 1'b1);
    check_output("rb_rvalid", resp_valid_a, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("rb_noresp", resp_valid_a, 1'b0);
    end
    single_beat("lw_post", 4'b0010, 32'h200, 32'h0, 32'h12345678, 0, 1'b0, 32'h200, 4'b1111, 32'h0, 32'h12345678);

    // Trapping instance
    exc_case("na_lh", 4'b0001, 32'h103);
    exc_case("na_ld", 4'b0011, 32'h100);

    req_valid_b = 1'b1; req_op_b = 4'b0010; req_addr_b = 32'h104;
    tick;
    req_valid_b = 1'b0;
    check_output("na_lw_mreq", mem_req_b, 1'b1);
    check_output("na_lw_addr", mem_addr_b, 32'h104);
    mem_ack_b = 1'b1; mem_rdata_b = 32'hCAFEF00D;
    tick;
    mem_ack_b = 1'b0; mem_rdata_b = '0;
    check_output("na_lw_rvalid", resp_valid_b, 1'b1);
    check_output("na_lw_exc", resp_exc_b, 1'b0);
    check_output("na_lw_rdata", resp_rdata_b, 32'hCAFEF00D);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
